// File: rtl/trig_pkg.sv
// ---------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the ESTHER trigger output stage:
//   - default widths for the delay/width/period counters, pulse count and
//     event counter
//   - 3-bit state encoding of the pulse-train FSM
//   - the initial wait constant used by the upstream trigger generator
//   - small state-decode helpers
// ---------------------------------------------------------------------------
package trig_pkg;

    localparam int CNT_WIDTH_DEF    = 24;
    localparam int NPULSE_WIDTH_DEF = 8;
    localparam int EVT_WIDTH_DEF    = 16;
    localparam int DLY_WIDTH        = 16;

    // Cycles the trigger generator waits after reset before it trusts its
    // inputs; kept here so both stages agree on the number.
    localparam int INIT_WAIT = 1250;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_DELAY = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_LOW   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // States reported on the busy output.
    function automatic logic st_is_busy(input logic [2:0] s);
        return (s == ST_DELAY) || (s == ST_HIGH) || (s == ST_LOW);
    endfunction

    // States in which a new trigger1 rise counts as an overrun: the train is
    // still owning the output, including its final done cycle.
    function automatic logic st_in_train(input logic [2:0] s);
        return st_is_busy(s) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/trig_down_counter.sv
// ---------------------------------------------------------------------------
// trig_down_counter
// Loadable down-counter shared by the delay, high and low phases.
// Load wins over enable; the count holds at zero.
//   clk        clock
//   rst_n      synchronous active-low reset (count -> 0)
//   i_load     load i_load_val this cycle
//   i_load_val value to load
//   i_en       decrement by one (when not loading and not zero)
//   o_zero     count is zero
// ---------------------------------------------------------------------------
module trig_down_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/trig_pulse_out.sv
// ---------------------------------------------------------------------------
// trig_pulse_out
// Output stage of the ESTHER trigger generator. After arm, each accepted
// rising edge of trigger1 starts a train: wait cfg_delay cycles, then emit
// cfg_npulse pulses cfg_width cycles high with period cfg_period, then one
// done cycle. The pulse_delay sampled at the accepted edge and a count of
// accepted trains are kept for software readout.
//
// Ports:
//   adc_clk, trig_reset_n        clock, synchronous active-low reset
//   trigger1, pulse_delay        trigger level and its measured delay
//   arm, abort, auto_rearm       control
//   cfg_delay/width/period/npulse train configuration (latched on arm)
//   trig_out                     shaped trigger (registered)
//   busy, armed, done, overrun   status (registered; overrun sticky)
//   last_delay, event_cnt        readout
// ---------------------------------------------------------------------------
module trig_pulse_out
    import trig_pkg::*;
#(
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int NPULSE_WIDTH = NPULSE_WIDTH_DEF,
    parameter int EVT_WIDTH    = EVT_WIDTH_DEF
) (
    input  logic                    adc_clk,
    input  logic                    trig_reset_n,
    input  logic                    trigger1,
    input  logic [DLY_WIDTH-1:0]    pulse_delay,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    auto_rearm,
    input  logic [CNT_WIDTH-1:0]    cfg_delay,
    input  logic [CNT_WIDTH-1:0]    cfg_width,
    input  logic [CNT_WIDTH-1:0]    cfg_period,
    input  logic [NPULSE_WIDTH-1:0] cfg_npulse,
    output logic                    trig_out,
    output logic                    busy,
    output logic                    armed,
    output logic                    done,
    output logic                    overrun,
    output logic [DLY_WIDTH-1:0]    last_delay,
    output logic [EVT_WIDTH-1:0]    event_cnt
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]              r_state;
    logic                    r_trig1_q;
    logic [CNT_WIDTH-1:0]    r_delay_s;
    logic [CNT_WIDTH-1:0]    r_width_s;
    logic [CNT_WIDTH-1:0]    r_low_s;
    logic [NPULSE_WIDTH-1:0] r_npulse_s;
    logic [NPULSE_WIDTH-1:0] r_pulse_left;
    logic                    r_trig_out;
    logic                    r_busy;
    logic                    r_armed;
    logic                    r_done;
    logic                    r_overrun;
    logic [DLY_WIDTH-1:0]    r_last_delay;
    logic [EVT_WIDTH-1:0]    r_event_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [2:0]              w_next_state;
    logic                    w_rise;
    logic                    w_accept;
    logic                    w_pulse_end;
    logic                    w_latch_cfg;
    logic                    w_cnt_load;
    logic [CNT_WIDTH-1:0]    w_cnt_load_val;
    logic                    w_cnt_en;
    logic                    w_cnt_zero;
    logic [CNT_WIDTH-1:0]    w_width_san;
    logic [CNT_WIDTH-1:0]    w_low_san;
    logic [NPULSE_WIDTH-1:0] w_npulse_san;
    logic                    w_trig_d;
    logic                    w_busy_d;
    logic                    w_armed_d;
    logic                    w_done_d;

    // trig1_q resets to 0, so a level already high at reset release is a rise.
    assign w_rise = trigger1 & ~r_trig1_q;

    // Sanitised configuration; zero width/count would make an empty train.
    assign w_width_san  = (cfg_width == '0) ? CNT_WIDTH'(1) : cfg_width;
    assign w_npulse_san = (cfg_npulse == '0) ? NPULSE_WIDTH'(1) : cfg_npulse;
    assign w_low_san    = (cfg_period > w_width_san) ? (cfg_period - w_width_san)
                                                     : CNT_WIDTH'(1);

    assign w_latch_cfg  = (r_state == ST_IDLE) && arm && !abort;

    // ------------------------------------------------------------------
    // Phase counter. Loaded with (length - 1) on entry to a phase, the
    // phase ends in the cycle the counter reads zero.
    // ------------------------------------------------------------------
    trig_down_counter #(
        .W (CNT_WIDTH)
    ) u_cnt (
        .clk        (adc_clk),
        .rst_n      (trig_reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // FSM: state register (outputs are registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (!trig_reset_n) begin
            r_state    <= ST_IDLE;
            r_trig_out <= 1'b0;
            r_busy     <= 1'b0;
            r_armed    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_trig_out <= w_trig_d;
            r_busy     <= w_busy_d;
            r_armed    <= w_armed_d;
            r_done     <= w_done_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and phase-counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_accept       = 1'b0;
        w_pulse_end    = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_en       = 1'b0;

        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) w_next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_accept   = 1'b1;
                        w_cnt_load = 1'b1;
                        if (r_delay_s == '0) begin
                            w_next_state   = ST_HIGH;
                            w_cnt_load_val = r_width_s - CNT_WIDTH'(1);
                        end else begin
                            w_next_state   = ST_DELAY;
                            w_cnt_load_val = r_delay_s - CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (w_cnt_zero) begin
                        w_next_state   = ST_HIGH;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = r_width_s - CNT_WIDTH'(1);
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_cnt_zero) begin
                        w_pulse_end = 1'b1;
                        if (r_pulse_left <= NPULSE_WIDTH'(1)) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state   = ST_LOW;
                            w_cnt_load     = 1'b1;
                            w_cnt_load_val = r_low_s - CNT_WIDTH'(1);
                        end
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_cnt_zero) begin
                        w_next_state   = ST_HIGH;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = r_width_s - CNT_WIDTH'(1);
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_next_state = auto_rearm ? ST_ARMED : ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the next state so the registered outputs
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_trig_d  = (w_next_state == ST_HIGH);
        w_busy_d  = st_is_busy(w_next_state);
        w_armed_d = (w_next_state == ST_ARMED);
        w_done_d  = (w_next_state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: edge detect, shadow config, pulse counter, readout
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (!trig_reset_n) begin
            r_trig1_q    <= 1'b0;
            r_delay_s    <= '0;
            r_width_s    <= '0;
            r_low_s      <= '0;
            r_npulse_s   <= '0;
            r_pulse_left <= '0;
            r_overrun    <= 1'b0;
            r_last_delay <= '0;
            r_event_cnt  <= '0;
        end else begin
            r_trig1_q <= trigger1;

            if (w_latch_cfg) begin
                r_delay_s  <= cfg_delay;
                r_width_s  <= w_width_san;
                r_low_s    <= w_low_san;
                r_npulse_s <= w_npulse_san;
            end

            if (w_accept) begin
                r_pulse_left <= r_npulse_s;
                r_last_delay <= pulse_delay;
                r_event_cnt  <= r_event_cnt + EVT_WIDTH'(1);
            end else if (w_pulse_end) begin
                r_pulse_left <= r_pulse_left - NPULSE_WIDTH'(1);
            end

            // Abort swallows a simultaneous rise or arm entirely.
            if (!abort) begin
                if (w_latch_cfg) begin
                    r_overrun <= 1'b0;
                end else if (w_rise && st_in_train(r_state)) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign trig_out   = r_trig_out;
    assign busy       = r_busy;
    assign armed      = r_armed;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign last_delay = r_last_delay;
    assign event_cnt  = r_event_cnt;

endmodule

// File: doc/trig_pulse_out.md
Name: trig_pulse_out

Overview:
- Downstream stage of the ESTHER trigger generator. It consumes `trigger1` and `pulse_delay` and produces the shaped output trigger train on `trig_out`.
- On each rising edge of `trigger1` it waits a programmable delay, then emits a programmable number of pulses with programmable width and period.
- It latches the measured `pulse_delay` and counts events for software readout.

Parameters:
- CNT_WIDTH, 24, width of the delay, width and period counters and the matching config ports.
- NPULSE_WIDTH, 8, width of the pulse-count config and the internal pulse counter.
- EVT_WIDTH, 16, width of the event counter.

Ports:
- adc_clk  in  1  system clock (250 MHz ADC clock).
- trig_reset_n  in  1  reset; synchronous, active-low.
- trigger1  in  1  second-pulse trigger from the trigger generator (level, registered at source).
- pulse_delay  in  16  measured delay from the trigger generator; valid in the cycle trigger1 rises.
- arm  in  1  one-cycle request: IDLE -> ARMED, latch config, clear overrun.
- abort  in  1  one-cycle request: any state -> IDLE.
- auto_rearm  in  1  1: return to ARMED after a train; 0: return to IDLE.
- cfg_delay  in  CNT_WIDTH  cycles from the trigger1 rise to the first pulse.
- cfg_width  in  CNT_WIDTH  pulse high time in cycles.
- cfg_period  in  CNT_WIDTH  pulse period in cycles.
- cfg_npulse  in  NPULSE_WIDTH  number of pulses per train.
- trig_out  out  1  shaped trigger output (registered).
- busy  out  1  high in DELAY, HIGH and LOW.
- armed  out  1  high in ARMED.
- done  out  1  one-cycle strobe after the last pulse of a train.
- overrun  out  1  sticky; set when trigger1 rises while busy.
- last_delay  out  16  pulse_delay captured at the accepted trigger1 rise.
- event_cnt  out  EVT_WIDTH  number of accepted trains; wraps.

Behaviour:
Reset and state:
- While trig_reset_n=0 at a clock edge:
  - state=IDLE.
  - trig_out, busy, armed, done and overrun = 0.
  - last_delay=0, event_cnt=0.
  - All counters = 0.
- States: IDLE, ARMED, DELAY, HIGH, LOW, DONE.

Edge detect:
- Register trig1_q <= trigger1.
- rise = trigger1 & ~trig1_q.
- After reset trig1_q=0, so a trigger1 already high at reset release counts as a rise.

Config latch:
- On IDLE+arm, latch cfg_* into shadow registers. All timing uses the shadow registers.
- Sanitising at latch time:
  - width 0 -> 1.
  - npulse 0 -> 1.
  - Low time = period - width; if period <= width, low time = 1.

Transitions and timing:
- IDLE: arm -> ARMED.
- ARMED: rise in cycle N ->
  - capture last_delay = pulse_delay;
  - event_cnt += 1;
  - if delay = 0, go to HIGH; else go to DELAY with the counter loaded with delay.
- trig_out is first high in cycle N+1+delay.
- DELAY: count down; go to HIGH when the count ends. trig_out is low.
- HIGH: trig_out=1 for exactly `width` cycles.
  - If the pulse just finished is the last one, go to DONE.
  - Otherwise go to LOW.
- LOW: trig_out=0 for exactly the low time, then HIGH.
- DONE: one cycle with done=1 and trig_out=0.
  - Next state is ARMED if auto_rearm=1 (config kept), else IDLE.
  - auto_rearm is sampled in DONE.

Boundary and simultaneous events:
- rise while in DELAY/HIGH/LOW/DONE: ignored; overrun <= 1 (sticky). last_delay and event_cnt are unchanged.
- rise in IDLE: ignored; overrun is not set.
- arm outside IDLE: ignored. arm in IDLE clears overrun.
- abort has priority over arm and rise in the same cycle. It returns to IDLE; trig_out=0 and busy=0 from the next cycle; no done strobe.
- Reset mid-train behaves like abort and also clears the outputs and counters.
- event_cnt wraps from all-ones to 0 without a flag.
- cfg_* changes while not in IDLE have no effect until the next arm.

Decomposition:
- Package trig_pkg:
  - state localparams (3-bit encoding);
  - CNT_WIDTH, NPULSE_WIDTH and EVT_WIDTH defaults;
  - initial wait constant shared with the trigger generator.
- One sub-module: trig_down_counter, a loadable CNT_WIDTH down-counter with load, enable and zero flag.
  - It is used for the delay, high and low phases (one instance, reloaded per phase).
  - The FSM, edge detect and shadow registers stay in trig_pulse_out.

Test Plan:
- Reset: hold trig_reset_n=0 for 5 cycles with trigger1=1 -> all outputs 0, state IDLE. After release with no arm, no pulse is produced.
- Single pulse: arm, delay=10, width=4, period=8, npulse=1. trigger1 rises at cycle N with pulse_delay=0x1234 -> trig_out high in cycles N+11..N+14, done at N+15, last_delay=0x1234, event_cnt=1.
- Train: delay=0, width=2, period=5, npulse=3, rise at N -> trig_out high in cycles N+1..2, N+6..7 and N+11..12; done at N+13. With auto_rearm=1, armed=1 at N+14.
- Degenerate config: width=0, period=0, npulse=0 -> one pulse, 1 cycle wide. Then width=6, period=3, npulse=2 -> high 6, low 1, high 6.
- Overrun: second trigger1 rise during HIGH -> overrun=1, event_cnt unchanged, train timing unaffected. A subsequent arm in IDLE clears overrun.
- Abort/reset: abort asserted in the same cycle as a rise in ARMED -> stays out of DELAY and is IDLE next cycle. A reset mid-LOW -> trig_out=0 and event_cnt=0 next cycle.
